// File: rtl/div_if.sv
// EX <-> divider request/response bundle: operands, control and the {remainder, quotient} result.
// The master modport is the EX stage side and the slave modport is the divider side.
interface div_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   div_op1_i;
  logic [DATA_W-1:0]   div_op2_i;
  logic                div_start_i;
  logic                div_sign_i;
  logic                div_cancel_i;
  logic [2*DATA_W-1:0] div_result_o;
  logic                div_final_o;

  modport master (
    output div_op1_i, div_op2_i, div_start_i, div_sign_i, div_cancel_i,
    input  div_result_o, div_final_o
  );

  modport slave (
    input  div_op1_i, div_op2_i, div_start_i, div_sign_i, div_cancel_i,
    output div_result_o, div_final_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// magnitudes divided unsigned, with the sign fix-up applied while the result is registered.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  div_bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   dvs_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;
  logic                final_q;

  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic                trial_ok;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;

  always_comb begin
    op1_abs = div_bus.div_op1_i;
    op2_abs = div_bus.div_op2_i;
    if (div_bus.div_sign_i && div_bus.div_op1_i[DATA_W-1]) op1_abs = -div_bus.div_op1_i;
    if (div_bus.div_sign_i && div_bus.div_op2_i[DATA_W-1]) op2_abs = -div_bus.div_op2_i;
  end

  // quo_q starts as the dividend: its MSB feeds the remainder while quotient bits enter at the LSB.
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    diff     = shifted - {1'b0, dvs_q};
    trial_ok = ~diff[DATA_W];
    rem_d    = trial_ok ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_d    = {quo_q[DATA_W-2:0], trial_ok};
    quo_fix  = neg_quo_q ? -quo_d : quo_d;
    rem_fix  = neg_rem_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      final_q   <= 1'b0;
    end else if (div_bus.div_cancel_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      final_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_bus.div_start_i) begin
            quo_q     <= op1_abs;
            dvs_q     <= op2_abs;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= div_bus.div_sign_i & (div_bus.div_op1_i[DATA_W-1] ^ div_bus.div_op2_i[DATA_W-1]);
            neg_rem_q <= div_bus.div_sign_i & div_bus.div_op1_i[DATA_W-1];
            state_q   <= (div_bus.div_op2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          state_q  <= S_END;
          result_q <= '0;
          final_q  <= 1'b1;
        end
        S_ON: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= S_END;
            result_q <= {rem_fix, quo_fix};
            final_q  <= 1'b1;
          end
        end
        S_END: begin
          // Result is held until EX drops start; a held start never re-launches from here.
          if (!div_bus.div_start_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            final_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          result_q <= '0;
          final_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_bus.div_result_o = result_q;
  assign div_bus.div_final_o  = final_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard-driven bench for div_unit: directed DIV/DIVU cases, cancel, reset and random traffic.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] sb_q[$];

  div_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'h0) return 64'h0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Launch one operation; operands are scrambled every cycle after sampling. Leaves start high in END.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [63:0] res);
    @(negedge clk);
    bus.div_op1_i   = a;
    bus.div_op2_i   = b;
    bus.div_sign_i  = s;
    bus.div_start_i = 1'b1;
    @(posedge clk);
    lat = 0;
    res = 64'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.div_final_o) begin
        res = bus.div_result_o;
        break;
      end
      bus.div_op1_i  = $urandom;
      bus.div_op2_i  = $urandom;
      bus.div_sign_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    bus.div_op1_i    = '0;
    bus.div_op2_i    = '0;
    bus.div_start_i  = 1'b0;
    bus.div_sign_i   = 1'b0;
    bus.div_cancel_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.div_final_o !== 1'b0 || bus.div_result_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: final=%b result=%h required final=0 result=0", bus.div_final_o, bus.div_result_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_final_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: final=%b required 0", bus.div_final_o);
    end
  endtask

  task automatic test_divu_basic();
    int lat;
    logic [63:0] res, exp;
    sb_q.push_back({32'h2, 32'hE});
    do_div(32'd100, 32'd7, 1'b0, lat, res);
    exp = sb_q.pop_front();
    $display("divu 100/7 lat=%0d result=%h", lat, res);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL divu_latency: got %0d required 33", lat);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL divu_100_7: got %h required %h", res, exp);
    end
    bus.div_start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_final_o !== 1'b0 || bus.div_result_o !== 64'h0) begin
      errors++;
      $display("FAIL divu_drop_start: final=%b result=%h required 0/0", bus.div_final_o, bus.div_result_o);
    end
  endtask

  task automatic test_signed();
    logic [31:0] a_tab[4] = '{32'hFFFF_FFF9, 32'h7, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] b_tab[4] = '{32'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [63:0] e_tab[4] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'hFFFF_FFFD},
                              {32'hFFFF_FFFF, 32'h3}, {32'h0, 32'h8000_0000}};
    int lat;
    logic [63:0] res, exp;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(e_tab[i]);
      do_div(a_tab[i], b_tab[i], 1'b1, lat, res);
      exp = sb_q.pop_front();
      $display("div %h/%h lat=%0d result=%h", a_tab[i], b_tab[i], lat, res);
      checks++;
      if (lat !== 33 || res !== exp) begin
        errors++;
        $display("FAIL signed_%0d: lat=%0d result=%h required lat=33 result=%h", i, lat, res, exp);
      end
      bus.div_start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_byzero();
    int lat;
    logic [63:0] res, exp;
    sb_q.push_back(64'h0);
    do_div(32'h1234_5678, 32'h0, 1'b0, lat, res);
    exp = sb_q.pop_front();
    $display("divu by zero lat=%0d result=%h", lat, res);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL byzero_latency: got %0d required 2", lat);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL byzero_result: got %h required %h", res, exp);
    end
    bus.div_start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int lat;
    logic [63:0] res, exp;
    sb_q.push_back({32'h0, 32'hFFFF_FFFF});
    do_div(32'hFFFF_FFFF, 32'h1, 1'b0, lat, res);
    exp = sb_q.pop_front();
    $display("divu ffffffff/1 lat=%0d result=%h", lat, res);
    checks++;
    if (lat !== 33 || res !== exp) begin
      errors++;
      $display("FAIL divu_max_by_1: lat=%0d result=%h required lat=33 result=%h", lat, res, exp);
    end
    bus.div_start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cancel();
    int lat;
    int seen;
    logic [63:0] res, exp;
    @(negedge clk);
    bus.div_op1_i   = 32'd1000;
    bus.div_op2_i   = 32'd3;
    bus.div_sign_i  = 1'b0;
    bus.div_start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    bus.div_cancel_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_final_o !== 1'b0 || bus.div_result_o !== 64'h0) begin
      errors++;
      $display("FAIL cancel_on: final=%b result=%h required 0/0", bus.div_final_o, bus.div_result_o);
    end
    bus.div_cancel_i = 1'b0;
    bus.div_start_i  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_final_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL cancel_no_final: final seen %0d cycles required 0", seen);
    end
    sb_q.push_back({32'h0, 32'h3});
    do_div(32'd9, 32'd3, 1'b0, lat, res);
    exp = sb_q.pop_front();
    $display("divu 9/3 after cancel lat=%0d result=%h", lat, res);
    checks++;
    if (lat !== 33 || res !== exp) begin
      errors++;
      $display("FAIL after_cancel: lat=%0d result=%h required lat=33 result=%h", lat, res, exp);
    end
    // Cancel also overrides the END hold while start is still high.
    bus.div_cancel_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_final_o !== 1'b0 || bus.div_result_o !== 64'h0) begin
      errors++;
      $display("FAIL cancel_end: final=%b result=%h required 0/0", bus.div_final_o, bus.div_result_o);
    end
    bus.div_cancel_i = 1'b0;
    bus.div_start_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_and_reset();
    int lat;
    int bad;
    logic [63:0] res, exp;
    sb_q.push_back(ref_div(32'd5000, 32'd77, 1'b0));
    do_div(32'd5000, 32'd77, 1'b0, lat, res);
    exp = sb_q.pop_front();
    $display("divu 5000/77 lat=%0d result=%h", lat, res);
    checks++;
    if (lat !== 33 || res !== exp) begin
      errors++;
      $display("FAIL hold_first: lat=%0d result=%h required lat=33 result=%h", lat, res, exp);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.div_op1_i  = $urandom;
      bus.div_op2_i  = $urandom;
      bus.div_sign_i = ~bus.div_sign_i;
      @(negedge clk);
      if (bus.div_final_o !== 1'b1 || bus.div_result_o !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_final_o !== 1'b0 || bus.div_result_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_in_end: final=%b result=%h required 0/0", bus.div_final_o, bus.div_result_o);
    end
    rst = 1'b0;
    bus.div_start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] res, exp;
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (b == 32'h0) b = 32'h5;
      if (i % 4 == 1) a = -a;
      s = 1'(i % 2);
      sb_q.push_back(ref_div(a, b, s));
      do_div(a, b, s, lat, res);
      exp = sb_q.pop_front();
      $display("op %0d sign=%0d %h/%h lat=%0d result=%h", i, s, a, b, lat, res);
      checks++;
      if (lat !== 33 || res !== exp) begin
        errors++;
        $display("FAIL b2b_%0d: lat=%0d result=%h required lat=33 result=%h", i, lat, res, exp);
      end
      bus.div_start_i = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_byzero();
    test_boundary();
    test_cancel();
    test_hold_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
